// File: rtl/uart_pkg.sv
// uart_pkg: encodings and defaults shared by the UART RX and TX paths.
// Holds the RX FSM state encoding, default frame geometry and a vote helper.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_PRESCALE   = 8;

    localparam logic [2:0] RX_ST_IDLE   = 3'd0;
    localparam logic [2:0] RX_ST_START  = 3'd1;
    localparam logic [2:0] RX_ST_DATA   = 3'd2;
    localparam logic [2:0] RX_ST_PARITY = 3'd3;
    localparam logic [2:0] RX_ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = RX_ST_IDLE,
        ST_START  = RX_ST_START,
        ST_DATA   = RX_ST_DATA,
        ST_PARITY = RX_ST_PARITY,
        ST_STOP   = RX_ST_STOP
    } rx_state_e;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_data_sampler.sv
// uart_rx_data_sampler: per-bit tick counter, three mid-bit samples and
// majority vote for the UART receiver.
// Ports: i_clk, i_rst (async active-low), i_active (frame in progress),
//   i_rx_s (synchronized line); o_tick_last (last tick of a bit),
//   o_vote_first (first tick with a valid vote), o_vote_valid, o_vote.
module uart_rx_data_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE = UART_PRESCALE,
    parameter int TICK_W   = $clog2(PRESCALE)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_active,
    input  logic i_rx_s,
    output logic o_tick_last,
    output logic o_vote_first,
    output logic o_vote_valid,
    output logic o_vote
);

    // With PRESCALE=4 the nominal vote tick falls past the bit end, so the
    // vote is taken on the last tick using the live third sample.
    localparam int  VOTE_I = (PRESCALE / 2 + 2 > PRESCALE - 1)
                           ? PRESCALE - 1 : PRESCALE / 2 + 2;
    localparam bit  LIVE   = (PRESCALE / 2 + 2 > PRESCALE - 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PRESCALE - 1);
    localparam logic [TICK_W-1:0] TICK_S0   = TICK_W'(PRESCALE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_S1   = TICK_W'(PRESCALE / 2);
    localparam logic [TICK_W-1:0] TICK_S2   = TICK_W'(PRESCALE / 2 + 1);
    localparam logic [TICK_W-1:0] TICK_VOTE = TICK_W'(VOTE_I);

    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        samp_q, samp_d;
    logic [2:0]        vote_in;

    always_comb begin
        tick_d = tick_q;
        samp_d = samp_q;
        if (!i_active || tick_q == TICK_LAST) begin
            tick_d = '0;
        end else begin
            tick_d = tick_q + TICK_W'(1);
        end
        if (i_active) begin
            if (tick_q == TICK_S0) samp_d[0] = i_rx_s;
            if (tick_q == TICK_S1) samp_d[1] = i_rx_s;
            if (tick_q == TICK_S2) samp_d[2] = i_rx_s;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            tick_q <= '0;
            samp_q <= 3'b111;
        end else begin
            tick_q <= tick_d;
            samp_q <= samp_d;
        end
    end

    always_comb begin
        vote_in = samp_q;
        if (LIVE && tick_q == TICK_S2) begin
            vote_in[2] = i_rx_s;
        end
    end

    assign o_vote       = maj3(vote_in);
    assign o_tick_last  = i_active && (tick_q == TICK_LAST);
    assign o_vote_first = i_active && (tick_q == TICK_VOTE);
    assign o_vote_valid = i_active && (tick_q >= TICK_VOTE);

endmodule

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: UART receive path. Synchronizes the line, detects the
// start edge, votes each bit, assembles the word LSB-first, checks stop/parity.
// Ports: i_clk, i_rst (async active-low), i_rx_in (idle-high line);
//   o_data (last good word), o_data_valid / o_stop_err / o_par_err (1-cycle
//   pulses), o_busy (frame in progress).
// Build option: UART_RX_PARITY_EN adds a parity bit between data and stop.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int PRESCALE   = UART_PRESCALE,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx_in,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_valid,
    output logic                  o_stop_err,
    output logic                  o_par_err,
    output logic                  o_busy
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    if (PRESCALE < 4 || (PRESCALE % 2) != 0) begin : g_bad_prescale
        $error("PRESCALE must be even and >= 4");
    end
    if (DATA_WIDTH < 2) begin : g_bad_width
        $error("DATA_WIDTH must be >= 2");
    end

    logic                  rx_meta_q, rx_meta_d;
    logic                  rx_s_q, rx_s_d;
    logic                  rx_prev_q, rx_prev_d;
    logic                  fall_q, fall_d;
    rx_state_e             state_q, state_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  stop_err_q, stop_err_d;
`ifdef UART_RX_PARITY_EN
    logic                  par_bad_q, par_bad_d;
    logic                  par_err_q, par_err_d;
`else
    logic                  unused_par_cfg;
`endif

    logic active;
    logic tick_last;
    logic vote_first;
    logic vote_valid;
    logic vote;
    logic stop_ok;

    assign active = (state_q != ST_IDLE);

    uart_rx_data_sampler #(
        .PRESCALE (PRESCALE)
    ) u_sampler (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_active     (active),
        .i_rx_s       (rx_s_q),
        .o_tick_last  (tick_last),
        .o_vote_first (vote_first),
        .o_vote_valid (vote_valid),
        .o_vote       (vote)
    );

    // Falling edge is registered once more, so an idle line that stays low
    // after a bad stop bit never produces a fresh start.
    always_comb begin
        rx_meta_d = i_rx_in;
        rx_s_d    = rx_meta_q;
        rx_prev_d = rx_s_q;
        fall_d    = rx_prev_q & ~rx_s_q;
    end

    assign stop_ok = vote_valid & vote;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        stop_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad_q;
        par_err_d  = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (fall_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
                if (vote_first && vote) begin
                    state_d = ST_IDLE;
                end else if (tick_last) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (vote_first) begin
                    shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
                end
                if (tick_last) begin
                    if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (vote_first) begin
                    par_bad_d = vote ^ (^shift_q) ^ PARITY_ODD;
                end
                if (tick_last) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick_last) begin
                    if (!stop_ok) begin
                        stop_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        par_err_d = 1'b1;
`endif
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                    // A start edge seen on the final stop tick is a
                    // zero-gap back-to-back frame.
                    state_d = fall_q ? ST_START : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            fall_q     <= 1'b0;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            stop_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= 1'b0;
            par_err_q  <= 1'b0;
`endif
        end else begin
            rx_meta_q  <= rx_meta_d;
            rx_s_q     <= rx_s_d;
            rx_prev_q  <= rx_prev_d;
            fall_q     <= fall_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            stop_err_q <= stop_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= par_bad_d;
            par_err_q  <= par_err_d;
`endif
        end
    end

    assign o_data       = data_q;
    assign o_data_valid = valid_q;
    assign o_stop_err   = stop_err_q;
    assign o_busy       = active;
`ifdef UART_RX_PARITY_EN
    assign o_par_err    = par_err_q;
`else
    assign o_par_err      = 1'b0;
    assign unused_par_cfg = PARITY_ODD;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: directed frames against uart_rx_deserializer
// with hand-computed words, pulse counts and latencies.
module tb_uart_rx_deserializer;

    localparam int P = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       stop_err;
    logic       par_err;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx_deserializer #(
        .DATA_WIDTH (8),
        .PRESCALE   (P),
        .PARITY_ODD (1'b0)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .i_rx_in      (rx),
        .o_data       (data),
        .o_data_valid (valid),
        .o_stop_err   (stop_err),
        .o_par_err    (par_err),
        .o_busy       (busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t_start = 0;

    int valid_cnt = 0;
    int stop_cnt = 0;
    int par_cnt = 0;
    int last_valid_cyc = 0;
    int last_stop_cyc = 0;
    int last_par_cyc = 0;
    int valid_cyc_q[$];
    logic [7:0] valid_data_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            valid_cyc_q.push_back(cyc);
            valid_data_q.push_back(data);
        end
        if (stop_err === 1'b1) begin
            stop_cnt++;
            last_stop_cyc = cyc;
        end
        if (par_err === 1'b1) begin
            par_cnt++;
            last_par_cyc = cyc;
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the next posedge is the first to see the start bit.
    task automatic send(input logic [7:0] d, input logic par_en,
                        input logic par_bit, input logic stop_bit);
        t_start = cyc + 1;
        rx = 1'b0;
        repeat (P) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (P) @(negedge clk);
        end
        if (par_en) begin
            rx = par_bit;
            repeat (P) @(negedge clk);
        end
        rx = stop_bit;
        repeat (P) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int s0;
        int p0;
        int first_busy;
        int last_busy;
        bit saw_busy;
        int n;

        repeat (3) @(negedge clk);
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_stop", 32'(stop_err), 32'h0);
        chk("rst_par", 32'(par_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        idle(10);

        // 1: clean frame, latency 10*P+3
        v0 = valid_cnt;
        s0 = stop_cnt;
        send(8'hA5, 1'b0, 1'b0, 1'b1);
        idle(20);
        chk("a5_count", 32'(valid_cnt - v0), 32'd1);
        chk("a5_lat", 32'(last_valid_cyc - t_start), 32'd83);
        chk("a5_data", 32'(data), 32'hA5);
        chk("a5_nostop", 32'(stop_cnt - s0), 32'd0);

        // 2: 2-cycle glitch aborts in START
        v0 = valid_cnt;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        saw_busy = 1'b0;
        first_busy = 0;
        last_busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                if (!saw_busy) first_busy = cyc;
                saw_busy = 1'b1;
                last_busy = cyc;
            end
        end
        chk("glitch_busy_seen", 32'(saw_busy), 32'd1);
        chk("glitch_busy_len", 32'(last_busy - first_busy + 1), 32'd7);
        chk("glitch_idle", 32'(busy), 32'd0);
        chk("glitch_nopulse", 32'(valid_cnt - v0), 32'd0);
        chk("glitch_data", 32'(data), 32'hA5);

        // 3: bad stop bit, line then stuck low
        v0 = valid_cnt;
        s0 = stop_cnt;
        send(8'h3C, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        chk("stop_count", 32'(stop_cnt - s0), 32'd1);
        chk("stop_lat", 32'(last_stop_cyc - t_start), 32'd83);
        chk("stop_novalid", 32'(valid_cnt - v0), 32'd0);
        chk("stop_data", 32'(data), 32'hA5);
        chk("stop_low_idle", 32'(busy), 32'd0);
        idle(20);
        chk("stop_rise_idle", 32'(busy), 32'd0);

        // 4: back-to-back, zero gap
        v0 = valid_cnt;
        send(8'h00, 1'b0, 1'b0, 1'b1);
        send(8'hFF, 1'b0, 1'b0, 1'b1);
        idle(20);
        n = valid_cnt - v0;
        chk("b2b_count", 32'(n), 32'd2);
        if (n == 2) begin
            chk("b2b_word0", 32'(valid_data_q[valid_data_q.size() - 2]),
                32'h00);
            chk("b2b_word1", 32'(valid_data_q[valid_data_q.size() - 1]),
                32'hFF);
            chk("b2b_gap", 32'(valid_cyc_q[valid_cyc_q.size() - 1] -
                               valid_cyc_q[valid_cyc_q.size() - 2]), 32'd80);
        end

`ifdef UART_RX_PARITY_EN
        // 5: even parity
        v0 = valid_cnt;
        p0 = par_cnt;
        send(8'h07, 1'b1, 1'b1, 1'b1);
        idle(20);
        chk("par_ok_count", 32'(valid_cnt - v0), 32'd1);
        chk("par_ok_lat", 32'(last_valid_cyc - t_start), 32'd91);
        chk("par_ok_data", 32'(data), 32'h07);
        chk("par_ok_noerr", 32'(par_cnt - p0), 32'd0);
        v0 = valid_cnt;
        s0 = stop_cnt;
        send(8'h07, 1'b1, 1'b0, 1'b1);
        idle(20);
        chk("par_bad_count", 32'(par_cnt - p0), 32'd1);
        chk("par_bad_lat", 32'(last_par_cyc - t_start), 32'd91);
        chk("par_bad_novalid", 32'(valid_cnt - v0), 32'd0);
        chk("par_bad_nostop", 32'(stop_cnt - s0), 32'd0);
`else
        p0 = 0;
        chk("par_never", 32'(par_cnt - p0), 32'd0);
`endif

        // 6: reset during data bit 4 of 0x5A
        v0 = valid_cnt;
        rx = 1'b0;
        repeat (P) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = 8'h5A >> i;
            repeat (P) @(negedge clk);
        end
        rx = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_data", 32'(data), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(100);
        chk("mid_rst_nopulse", 32'(valid_cnt - v0), 32'd0);
        send(8'h81, 1'b0, 1'b0, 1'b1);
        idle(20);
        chk("after_rst_count", 32'(valid_cnt - v0), 32'd1);
        chk("after_rst_data", 32'(data), 32'h81);
        chk("after_rst_lat", 32'(last_valid_cyc - t_start), 32'd83);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
